mem_op_issue_queue: RTL and testbench

MEM_OP_ISSUE_QUEUE -- requirements
Module: mem_op_issue_queue

---
 rtl/mem_op_issue_queue.sv | 154 +++++++++++++++
 tb/tb_mem_op_issue_queue.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_op_issue_queue.sv
// Issue queue for load/store ops: circular FIFO feeding one op at a time
// to the ld/st FSM, with response timeout and flush/kill handling.
module mem_op_issue_queue #(
  parameter int DEPTH   = 4,
  parameter int ADDR_W  = 40,
  parameter int DATA_W  = 64,
  parameter int TIMEOUT = 255
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enq_valid_i,
  output logic                     enq_ready_o,
  input  logic                     enq_is_store_i,
  input  logic [ADDR_W-1:0]        enq_addr_i,
  input  logic [DATA_W-1:0]        enq_data_i,
  input  logic [1:0]               enq_size_i,
  input  logic                     flush_i,
  output logic                     is_load_o,
  output logic                     is_store_o,
  output logic [ADDR_W-1:0]        op_addr_o,
  output logic [DATA_W-1:0]        op_data_o,
  output logic [1:0]               op_size_o,
  output logic                     kill_mem_op_o,
  input  logic                     ld_resp_valid_i,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     timeout_o
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0]   FULL_CNT = (PW+1)'(DEPTH);
  localparam logic [PW:0]   ONE_CNT  = (PW+1)'(1);
  localparam logic [PW-1:0] ONE_PTR  = PW'(1);
  localparam logic [7:0]    TO       = 8'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_RESP,
    KILL
  } state_e;

  state_e            state_q;
  logic [PW-1:0]     head_q, tail_q, wr_idx;
  logic [PW:0]       count_q, count_d;
  logic [7:0]        wcnt_q, wcnt_d;
  logic              timeout_q;
  logic              is_load_q, is_store_q, kill_q;

  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [1:0]        size_mem [DEPTH];
  logic              st_mem   [DEPTH];

  logic full, empty, enq_fire, pop, kill_clr;

  assign full     = (count_q == FULL_CNT);
  assign empty    = (count_q == '0);
  assign enq_fire = enq_valid_i & ~full & ~flush_i;
  assign pop      = (state_q == WAIT_RESP) & ld_resp_valid_i & ~flush_i;
  assign kill_clr = (state_q == KILL);
  // While killing, the queue restarts at slot 0 so a same-cycle enqueue survives
  assign wr_idx   = kill_clr ? '0 : tail_q;
  assign wcnt_d   = wcnt_q + 8'd1;

  always_comb begin
    count_d = count_q;
    if (enq_fire & ~pop)
      count_d = count_q + ONE_CNT;
    else if (~enq_fire & pop)
      count_d = count_q - ONE_CNT;
  end

  always_ff @(posedge clk) begin
    if (enq_fire) begin
      addr_mem[wr_idx] <= enq_addr_i;
      data_mem[wr_idx] <= enq_data_i;
      size_mem[wr_idx] <= enq_size_i;
      st_mem[wr_idx]   <= enq_is_store_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (kill_clr) begin
      head_q  <= '0;
      tail_q  <= enq_fire ? ONE_PTR : '0;
      count_q <= enq_fire ? ONE_CNT : '0;
    end else begin
      if (enq_fire) tail_q <= tail_q + ONE_PTR;
      if (pop)      head_q <= head_q + ONE_PTR;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      wcnt_q     <= '0;
      timeout_q  <= 1'b0;
      is_load_q  <= 1'b0;
      is_store_q <= 1'b0;
      kill_q     <= 1'b0;
    end else begin
      is_load_q  <= 1'b0;
      is_store_q <= 1'b0;
      kill_q     <= 1'b0;
      if (flush_i) begin
        state_q <= KILL;
        kill_q  <= 1'b1;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (!empty) begin
              state_q    <= ISSUE;
              is_store_q <= st_mem[head_q];
              is_load_q  <= ~st_mem[head_q];
            end
          end
          ISSUE: begin
            state_q <= WAIT_RESP;
            wcnt_q  <= '0;
          end
          WAIT_RESP: begin
            if (ld_resp_valid_i) begin
              state_q <= IDLE;
            end else if (wcnt_d == TO) begin
              state_q   <= KILL;
              timeout_q <= 1'b1;
              kill_q    <= 1'b1;
            end else begin
              wcnt_q <= wcnt_d;
            end
          end
          KILL: state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign enq_ready_o   = ~full;
  assign is_load_o     = is_load_q;
  assign is_store_o    = is_store_q;
  assign kill_mem_op_o = kill_q;
  assign timeout_o     = timeout_q;
  assign count_o       = count_q;
  assign op_addr_o     = empty ? '0 : addr_mem[head_q];
  assign op_data_o     = empty ? '0 : data_mem[head_q];
  assign op_size_o     = empty ? '0 : size_mem[head_q];

endmodule

// File: tb/tb_mem_op_issue_queue.sv
// Scoreboard bench for mem_op_issue_queue: directed ops, monitor checks
// every issue/kill pulse against the expected event queue.
module tb_mem_op_issue_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        enq_valid, enq_ready, enq_st;
  logic [39:0] enq_addr;
  logic [63:0] enq_data;
  logic [1:0]  enq_size;
  logic        flush, is_load, is_store, kill, resp, timeout;
  logic [39:0] op_addr;
  logic [63:0] op_data;
  logic [1:0]  op_size;
  logic [2:0]  count;

  always #5 clk = ~clk;

  mem_op_issue_queue #(
    .DEPTH(4), .ADDR_W(40), .DATA_W(64), .TIMEOUT(4)
  ) dut (
    .clk(clk), .rst(rst),
    .enq_valid_i(enq_valid), .enq_ready_o(enq_ready),
    .enq_is_store_i(enq_st), .enq_addr_i(enq_addr),
    .enq_data_i(enq_data), .enq_size_i(enq_size),
    .flush_i(flush), .is_load_o(is_load), .is_store_o(is_store),
    .op_addr_o(op_addr), .op_data_o(op_data), .op_size_o(op_size),
    .kill_mem_op_o(kill), .ld_resp_valid_i(resp),
    .count_o(count), .timeout_o(timeout)
  );

  typedef struct {
    logic [1:0]  kind;
    logic [39:0] addr;
  } ev_t;

  ev_t sb[$];
  int  n_cmp = 0;
  int  n_bad = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic expect_ev(logic [1:0] k, logic [39:0] a);
    ev_t e;
    e.kind = k;
    e.addr = a;
    sb.push_back(e);
  endtask

  // kind: 1 load, 2 store, 3 kill
  int         cyc  = 0;
  int         last = -100;
  logic [1:0] mk;
  ev_t        me;

  always @(negedge clk) begin
    cyc++;
    if (!rst && (is_load || is_store || kill)) begin
      mk = kill ? 2'd3 : (is_store ? 2'd2 : 2'd1);
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_pulse: got kind %0d want none", mk);
      end else begin
        me = sb.pop_front();
        chk("ev_kind", 64'(mk), 64'(me.kind));
        if (mk != 2'd3) begin
          chk("ev_addr", 64'(op_addr), 64'(me.addr));
          chk("issue_gap", 64'((cyc - last) >= 3), 64'd1);
          last = cyc;
        end else begin
          last = -100;
        end
      end
    end
  end

  task automatic enq1(logic st, logic [39:0] a, logic [63:0] d,
                      logic [1:0] sz);
    enq_valid = 1'b1;
    enq_st    = st;
    enq_addr  = a;
    enq_data  = d;
    enq_size  = sz;
    @(posedge clk);
    #1;
    enq_valid = 1'b0;
  endtask

  task automatic serve_one(int dly);
    int n = 0;
    bit seen = 1'b0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      seen = is_load | is_store;
    end
    if (!seen) begin
      n_cmp++;
      n_bad++;
      $display("FAIL serve_wait: got no issue in 40 cycles want pulse");
    end else begin
      @(posedge clk);
      repeat (dly - 1) @(posedge clk);
      #1 resp = 1'b1;
      @(posedge clk);
      #1 resp = 1'b0;
    end
  endtask

  initial begin
    int n;
    rst = 1'b1;
    enq_valid = 0; enq_st = 0; enq_addr = '0; enq_data = '0;
    enq_size = '0; flush = 0; resp = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_is_load", 64'(is_load), 64'd0);
    chk("rst_is_store", 64'(is_store), 64'd0);
    chk("rst_kill", 64'(kill), 64'd0);
    chk("rst_timeout", 64'(timeout), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", 64'(enq_ready), 64'd1);

    // single load, response straight away
    expect_ev(2'd1, 40'h1000);
    enq1(1'b0, 40'h1000, 64'h0, 2'd2);
    @(negedge clk);
    chk("t1_count1", 64'(count), 64'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t1_is_load", 64'(is_load), 64'd1);
    chk("t1_addr", 64'(op_addr), 64'h1000);
    chk("t1_size", 64'(op_size), 64'd2);
    @(posedge clk); #1 resp = 1'b1;
    @(posedge clk); #1 resp = 1'b0;
    @(negedge clk);
    chk("t1_count0", 64'(count), 64'd0);
    chk("t1_addr_empty", 64'(op_addr), 64'd0);

    // fill to full, 5th offer held, resp same cycle as full offer
    for (int i = 0; i < 5; i++)
      expect_ev((i % 2) ? 2'd2 : 2'd1, 40'h2000 + 40'(i));
    for (int i = 0; i < 4; i++)
      enq1(1'(i % 2), 40'h2000 + 40'(i), 64'hD0 + 64'(i), 2'(i));
    enq_valid = 1'b1; enq_st = 1'b0;
    enq_addr = 40'h2004; enq_data = 64'hD4; enq_size = 2'd0;
    @(negedge clk);
    chk("t2_ready_full", 64'(enq_ready), 64'd0);
    chk("t2_count4", 64'(count), 64'd4);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t2_count_held", 64'(count), 64'd4);
    resp = 1'b1;
    @(posedge clk); #1 resp = 1'b0;
    @(negedge clk);
    chk("t2_full_pop_count3", 64'(count), 64'd3);
    chk("t2_ready_after_pop", 64'(enq_ready), 64'd1);
    @(posedge clk); #1 enq_valid = 1'b0;
    chk("t2_5th_accepted", 64'(count), 64'd4);
    repeat (4) serve_one(3);
    @(negedge clk);
    chk("t2_drained", 64'(count), 64'd0);

    // store then load, each answered in third wait cycle
    expect_ev(2'd2, 40'h3000);
    expect_ev(2'd1, 40'h3008);
    enq1(1'b1, 40'h3000, 64'hCAFE_F00D_1234_5678, 2'd3);
    enq1(1'b0, 40'h3008, 64'h0, 2'd1);
    chk("t3_st_data", op_data, 64'hCAFE_F00D_1234_5678);
    chk("t3_st_size", 64'(op_size), 64'd3);
    serve_one(3);
    serve_one(3);
    @(negedge clk);
    chk("t3_count0", 64'(count), 64'd0);

    // flush while waiting with three queued
    expect_ev(2'd1, 40'h4000);
    expect_ev(2'd3, 40'h0);
    for (int i = 0; i < 3; i++)
      enq1(1'b0, 40'h4000 + 40'(i), 64'h0, 2'd0);
    @(negedge clk);
    chk("t4_count3", 64'(count), 64'd3);
    flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    chk("t4_kill", 64'(kill), 64'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t4_count0", 64'(count), 64'd0);
    chk("t4_kill_once", 64'(kill), 64'd0);
    repeat (8) @(posedge clk);
    @(negedge clk);
    chk("t4_still_empty", 64'(count), 64'd0);
    chk("t4_ready", 64'(enq_ready), 64'd1);

    // no response: timeout after four wait cycles
    expect_ev(2'd1, 40'h5000);
    expect_ev(2'd3, 40'h0);
    enq1(1'b0, 40'h5000, 64'h0, 2'd0);
    n = 0;
    while (!timeout && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("t5_timeout", 64'(timeout), 64'd1);
    chk("t5_timeout_cycle", 64'(n), 64'd7);
    chk("t5_kill_with_timeout", 64'(kill), 64'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t5_count0", 64'(count), 64'd0);
    chk("t5_timeout_sticky", 64'(timeout), 64'd1);

    // reset during wait drops the op silently
    expect_ev(2'd1, 40'h6000);
    enq1(1'b0, 40'h6000, 64'h0, 2'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_rst_count", 64'(count), 64'd0);
    chk("t6_rst_timeout", 64'(timeout), 64'd0);
    chk("t6_rst_kill", 64'(kill), 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("t6_count_after", 64'(count), 64'd0);
    chk("t6_ready_after", 64'(enq_ready), 64'd1);

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
